// File: rtl/clk_tick_monitor.sv
// ---------------------------------------------------------------------------------------------
// clk_tick_monitor
//
// Watches a slow clock (Clk_in) that is asynchronous to the system clock (Clk). It emits
// one-cycle pulses per accepted rising/falling edge, measures the rising-to-rising period in Clk
// cycles, and tracks whether the period is stable (Locked) or whether the input has gone quiet
// for too long (Lost).
//
// Ports:
//   Clk           in   system clock, all logic on its rising edge
//   Reset_n       in   asynchronous active-low reset
//   Clk_in        in   monitored clock, asynchronous to Clk
//   Tick          out  one-cycle pulse per accepted Clk_in rising edge
//   Tick_fall     out  one-cycle pulse per accepted Clk_in falling edge
//   Period        out  last measured rising-to-rising interval in Clk cycles
//   Period_valid  out  one-cycle pulse when Period is updated (coincides with Tick)
//   Locked        out  high while the period is stable within TOL
//   Lost          out  high after TIMEOUT cycles without an accepted rising edge
//
// Optional build macro:
//   CLK_MON_GLITCH_FILTER_EN  accept a synchronized level only after it has been stable for
//                             3 consecutive Clk cycles (adds one cycle of latency).
// ---------------------------------------------------------------------------------------------
module clk_tick_monitor #(
    parameter int unsigned         PERIOD_W = 26,
    parameter logic [PERIOD_W-1:0] TIMEOUT  = PERIOD_W'(1_000_000),
    parameter logic [PERIOD_W-1:0] TOL      = PERIOD_W'(2)
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                Clk_in,
    output logic                Tick,
    output logic                Tick_fall,
    output logic [PERIOD_W-1:0] Period,
    output logic                Period_valid,
    output logic                Locked,
    output logic                Lost
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StMeasure = 2'd1,
        StLocked  = 2'd2,
        StLost    = 2'd3
    } state_e;

    // Synchronizer and history flops. Reset to 0 so a Clk_in that is already high at reset
    // release is seen as one rising edge.
    logic sync1_q, sync2_q, hist_q;
    logic acc_rise, acc_fall;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= Clk_in;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

`ifdef CLK_MON_GLITCH_FILTER_EN
    // The synchronized level is accepted once sync2/hist/hist2 agree, i.e. it has been sampled
    // identically on 3 consecutive Clk edges. acc_q is the accepted (filtered) level.
    logic hist2_q, acc_q;
    logic stable;

    always_comb begin
        stable   = (sync2_q == hist_q) && (hist_q == hist2_q);
        acc_rise = stable && sync2_q && !acc_q;
        acc_fall = stable && !sync2_q && acc_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hist2_q <= 1'b0;
            acc_q   <= 1'b0;
        end else begin
            hist2_q <= hist_q;
            if (stable) begin
                acc_q <= sync2_q;
            end
        end
    end
`else
    // Unfiltered: every synchronized transition is an accepted edge. The detection is
    // registered once so the output pulse lands 3 cycles after the first sampling edge.
    logic rise_q, fall_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= sync2_q && !hist_q;
            fall_q <= !sync2_q && hist_q;
        end
    end

    always_comb begin
        acc_rise = rise_q;
        acc_fall = fall_q;
    end
`endif

    // Measurement and lock tracking.
    state_e              state_q;
    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] prev_q;
    logic                prev_vld_q;
    logic [PERIOD_W-1:0] period_q;
    logic                tick_q, tick_fall_q, pvalid_q, locked_q, lost_q;

    logic [PERIOD_W-1:0] diff;
    logic                in_tol;
    logic                timeout_hit;

    always_comb begin
        // Absolute difference, ordered so the subtraction never wraps.
        diff        = (cnt_q >= prev_q) ? (cnt_q - prev_q) : (prev_q - cnt_q);
        in_tol      = (diff <= TOL);
        timeout_hit = (cnt_q >= TIMEOUT);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            period_q    <= '0;
            tick_q      <= 1'b0;
            tick_fall_q <= 1'b0;
            pvalid_q    <= 1'b0;
            locked_q    <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            tick_q      <= acc_rise;
            tick_fall_q <= acc_fall;
            pvalid_q    <= 1'b0;

            if (acc_rise) begin
                cnt_q <= PERIOD_W'(1);
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + PERIOD_W'(1);
            end

            // A rising edge takes priority over a timeout in the same cycle.
            if (acc_rise) begin
                unique case (state_q)
                    StIdle, StLost: begin
                        // No complete interval yet; start fresh with no comparison history.
                        state_q    <= StMeasure;
                        prev_vld_q <= 1'b0;
                        locked_q   <= 1'b0;
                        lost_q     <= 1'b0;
                    end
                    StMeasure: begin
                        period_q   <= cnt_q;
                        pvalid_q   <= 1'b1;
                        prev_q     <= cnt_q;
                        prev_vld_q <= 1'b1;
                        if (prev_vld_q && in_tol) begin
                            state_q  <= StLocked;
                            locked_q <= 1'b1;
                        end
                    end
                    StLocked: begin
                        period_q <= cnt_q;
                        pvalid_q <= 1'b1;
                        prev_q   <= cnt_q;
                        if (!in_tol) begin
                            state_q  <= StMeasure;
                            locked_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end else if (timeout_hit && (state_q != StLost)) begin
                state_q  <= StLost;
                locked_q <= 1'b0;
                lost_q   <= 1'b1;
            end
        end
    end

    assign Tick         = tick_q;
    assign Tick_fall    = tick_fall_q;
    assign Period       = period_q;
    assign Period_valid = pvalid_q;
    assign Locked       = locked_q;
    assign Lost         = lost_q;

endmodule

// File: doc/clk_tick_monitor.md
CLK_TICK_MONITOR -- requirements
Module: clk_tick_monitor

Interface
REQ-001 Parameter PERIOD_W, default 26: width of the period counter and the Period output.
REQ-002 Parameter TIMEOUT, default 26'd1_000_000: number of Clk cycles without an accepted rising edge before the input clock is declared lost.
REQ-003 Parameter TOL, default 26'd2: maximum allowed difference, in Clk cycles, between consecutive periods while locked.
REQ-004 Clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 Clk_in  input  1  slow divided clock to monitor; asynchronous to Clk.
REQ-007 Tick  output  1  one-cycle pulse per accepted Clk_in rising edge.
REQ-008 Tick_fall  output  1  one-cycle pulse per accepted Clk_in falling edge.
REQ-009 Period  output  PERIOD_W  last measured rising-to-rising interval, in Clk cycles.
REQ-010 Period_valid  output  1  one-cycle pulse when Period is updated.
REQ-011 Locked  output  1  high while the state is LOCKED.
REQ-012 Lost  output  1  high while the state is LOST.

Function
REQ-013 Clk_in SHALL pass through a 2-flop synchronizer, then a history flop; edges SHALL be detected on the synchronized level.
REQ-014 Tick and Tick_fall SHALL be registered, and SHALL assert exactly 3 Clk cycles after the first Clk edge that samples the new Clk_in level (4 cycles with the filter enabled).
REQ-015 Period counter: on an accepted rising edge it SHALL load 1; otherwise it SHALL increment; it SHALL saturate at 2^PERIOD_W-1.
REQ-016 On an accepted rising edge in MEASURE or LOCKED, Period SHALL take the counter value and Period_valid SHALL pulse in the same cycle as Tick; Clk_in of period P SHALL yield Period = P.
REQ-017 The previous Period SHALL be held in an internal register for comparison; the difference SHALL be the absolute value, computed unsigned without wrap.
REQ-018 States: IDLE, MEASURE, LOCKED, LOST; the reset state SHALL be IDLE.
REQ-019 IDLE: the first accepted rising edge SHALL go to MEASURE with no Period_valid (no interval exists yet).
REQ-020 MEASURE: the second edge SHALL produce Period_valid without a comparison; each subsequent edge whose period is within TOL of the previous period SHALL go to LOCKED.
REQ-021 LOCKED: an edge whose period differs from the previous period by more than TOL SHALL go to MEASURE; Period_valid still pulses for that edge.
REQ-022 In MEASURE, LOCKED or IDLE, a counter value reaching TIMEOUT with no rising edge SHALL go to LOST; IDLE SHALL count from reset.
REQ-023 LOST: the next accepted rising edge SHALL go to MEASURE with counter = 1 and no Period_valid; the comparison history SHALL be cleared.
REQ-024 If an edge and a timeout occur in the same cycle, the edge SHALL win.
REQ-025 Tick_fall SHALL never affect the state or the counter.

Reset
REQ-026 Reset_n low SHALL clear all flops asynchronously: Tick, Tick_fall, Period_valid, Locked and Lost to 0; Period to 0; state to IDLE; the counter to 0.
REQ-027 Synchronizer flops SHALL reset to 0, so that a Clk_in that is high at reset release produces one Tick.
REQ-028 Reset asserted mid-measurement SHALL discard the history; no Period_valid SHALL be produced for an interval that spans reset.

Configuration
REQ-029 Macro CLK_MON_GLITCH_FILTER_EN: when defined, the synchronized level SHALL be accepted only after it has been stable for 3 consecutive Clk cycles, and latency SHALL be +1 cycle versus REQ-014 base.
REQ-030 When the macro is undefined, there SHALL be no filter, and every synchronized transition SHALL be an accepted edge.

Verification
REQ-031 Clk_in period 10 (5 high / 5 low), TOL=2 -> Tick every 10 cycles; Period=10 from the 2nd edge; Locked after the 3rd edge; Tick_fall 5 cycles after each Tick.
REQ-032 Period sequence 10, 11, 10 with TOL=1 -> Locked held; then a period of 14 -> Locked drops on that edge, Period=14, state MEASURE.
REQ-033 TIMEOUT=64, Clk_in held low after lock -> Lost=1 and Locked=0 at counter=64; next rising edge -> Lost=0, no Period_valid.
REQ-034 Reset_n pulsed low mid-period -> all outputs 0 immediately (asynchronously); the first edge after release gives no Period_valid.
REQ-035 2-cycle high glitch on Clk_in: with CLK_MON_GLITCH_FILTER_EN -> no Tick; without -> Tick and Tick_fall both pulse.
REQ-036 Edge and timeout in the same cycle (TIMEOUT=10, period 10) -> no LOST; Period_valid with Period=10.
